// File: rtl/targ_fb_gen_if.sv
// Bundle of the multi-lane resolution inputs and the single feedback
// record output of the target-predictor feedback generator.
interface targ_fb_gen_if #(
    parameter int num_lanes  = 4,
    parameter int addr_width = 32
);
    logic [num_lanes-1:0]                 res_valid;
    logic [num_lanes-1:0][addr_width-1:0] res_base_pc;
    logic [num_lanes-1:0][addr_width-1:0] res_targ;

    logic                  fb_valid;
    logic [addr_width-1:0] fb_base_pc;
    logic [addr_width-1:0] fb_targ_addr;

    // Execution side: presents resolutions, observes feedback.
    modport master (
        output res_valid, res_base_pc, res_targ,
        input  fb_valid, fb_base_pc, fb_targ_addr
    );

    // Feedback generator side.
    modport slave (
        input  res_valid, res_base_pc, res_targ,
        output fb_valid, fb_base_pc, fb_targ_addr
    );
endinterface

// File: rtl/targ_fb_gen.sv
// Target-predictor feedback generator: coalesces per-cycle indirect-branch
// resolutions from several lanes, buffers them in a small FIFO and emits at
// most one registered feedback record per cycle.
module targ_fb_gen #(
    parameter int num_lanes      = 4,
    parameter int addr_width     = 32,
    parameter int fifo_depth     = 8,
    parameter int drop_cnt_width = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    targ_fb_gen_if.slave                  bus,
    output logic [$clog2(fifo_depth):0]   fifo_cnt,
    output logic [drop_cnt_width-1:0]     drop_cnt
);
    localparam int ptr_w  = $clog2(fifo_depth);
    localparam int cnt_w  = ptr_w + 1;
    localparam int lane_w = $clog2(num_lanes + 1);
    localparam int sum_w  = drop_cnt_width + lane_w;

    typedef struct packed {
        logic [addr_width-1:0] base_pc;
        logic [addr_width-1:0] targ;
    } fb_entry_t;

    fb_entry_t                 mem_q [fifo_depth];
    logic [ptr_w-1:0]          head_q, head_d;
    logic [ptr_w-1:0]          tail_q, tail_d;
    logic [cnt_w-1:0]          cnt_q, cnt_d;
    logic [drop_cnt_width-1:0] drop_q, drop_d;
    logic                      fb_valid_q, fb_valid_d;
    fb_entry_t                 fb_q, fb_d;

    logic [num_lanes-1:0]      keep;
    logic                      pop;
    logic [cnt_w-1:0]          free_slots;
    logic [cnt_w-1:0]          n_enq;
    logic [lane_w-1:0]         n_drop;
    logic [num_lanes-1:0]      wr_en;
    logic [ptr_w-1:0]          wr_idx [num_lanes];
    logic [sum_w-1:0]          drop_sum;

    // A lane survives unless a lower-indexed valid lane carries the same (pc, target).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        keep = '0;
        for (int i = 0; i < num_lanes; i++) begin
            keep[i] = bus.res_valid[i];
            for (int j = 0; j < i; j++) begin
                if (bus.res_valid[j] &&
                    bus.res_base_pc[j] == bus.res_base_pc[i] &&
                    bus.res_targ[j]    == bus.res_targ[i])
                    keep[i] = 1'b0;
            end
        end
    end

    // Allocate surviving lanes to consecutive tail slots; the rest are drops.
    always_comb begin
        pop        = en && !flush && (cnt_q != '0);
        free_slots = cnt_w'(fifo_depth) - cnt_q + cnt_w'(pop);
        n_enq      = '0;
        n_drop     = '0;
        wr_en      = '0;
        for (int i = 0; i < num_lanes; i++) begin
            wr_idx[i] = '0;
            if (keep[i] && !flush) begin
                if (n_enq < free_slots) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = tail_q + n_enq[ptr_w-1:0];
                    // NOTE: blocking updates here are intentional; later lanes see the running count.
                    n_enq     = n_enq + cnt_w'(1);
                end else begin
                    n_drop = n_drop + lane_w'(1);
                end
            end
        end
    end

    // Next-state for pointers, occupancy, feedback record and drop counter.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        fb_valid_d = 1'b0;
        fb_d       = fb_q;
        drop_sum   = sum_w'(drop_q) + sum_w'(n_drop);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                fb_valid_d = 1'b1;
                fb_d       = mem_q[head_q];
                head_d     = head_q + ptr_w'(1);
            end
            tail_d = tail_q + n_enq[ptr_w-1:0];
            cnt_d  = cnt_q + n_enq - cnt_w'(pop);
            drop_d = (drop_sum > sum_w'({drop_cnt_width{1'b1}})) ? '1
                                                                 : drop_sum[drop_cnt_width-1:0];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
            fb_valid_q <= 1'b0;
            fb_q       <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            fb_valid_q <= fb_valid_d;
            fb_q       <= fb_d;
        end
    end

    // FIFO storage write port, one write per allocated lane.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy and pointers alone define which entries are live.
        for (int i = 0; i < num_lanes; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= '{base_pc: bus.res_base_pc[i], targ: bus.res_targ[i]};
            end
        end
    end

    assign bus.fb_valid     = fb_valid_q;
    assign bus.fb_base_pc   = fb_q.base_pc;
    assign bus.fb_targ_addr = fb_q.targ;
    assign fifo_cnt         = cnt_q;
    assign drop_cnt         = drop_q;
endmodule

// File: doc/targ_fb_gen.md
Name: targ_fb_gen

Overview:
- Producer side of target-predictor training: collects resolved indirect-branch outcomes (base PC, actual target) from the parallel-evaluation execution lanes.
- Buffers and coalesces them in a small FIFO.
- Emits at most one registered feedback record per cycle toward the target predictor.
- Decouples bursty multi-lane resolution from the predictor's single feedback port.

Parameters:
- num_lanes, 4, number of execution lanes that can resolve a branch per cycle (power of two, >=1)
- addr_width, 32, width of PC and target addresses
- fifo_depth, 8, feedback FIFO entries (power of two, >=2)
- drop_cnt_width, 16, width of saturating drop counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  enable; gates popping/emission only
- flush  input  1  discard all buffered and in-flight feedback
- res_valid  input  [num_lanes]  per-lane resolution valid
- res_base_pc  input  [num_lanes][addr_width]  per-lane branch PC
- res_targ  input  [num_lanes][addr_width]  per-lane resolved target
- fb_valid  output  1  feedback record valid (registered)
- fb_base_pc  output  addr_width  feedback branch PC (registered)
- fb_targ_addr  output  addr_width  feedback target (registered)
- fifo_cnt  output  clog2(fifo_depth)+1  current FIFO occupancy
- drop_cnt  output  drop_cnt_width  saturating count of discarded resolutions

Behaviour:
- Reset is synchronous and active-high; reset clk rst. On rst: FIFO empty, head/tail = 0, fifo_cnt = 0, fb_valid = 0, fb_base_pc = 0, fb_targ_addr = 0, drop_cnt = 0. rst overrides flush and en.
- Intra-cycle coalescing: lane i is a duplicate if some lane j<i is valid with identical (base_pc, targ). Duplicates are neither enqueued nor counted as drops.
- Enqueue order: surviving lanes are written in ascending lane index at consecutive tail slots.
- Free slots: fifo_depth - fifo_cnt + (pop this cycle ? 1 : 0).
- Lanes beyond available free slots are dropped (lowest indices win). drop_cnt += number dropped, saturating at all-ones.
- Pop: when en=1 and fifo_cnt>0, the head entry is loaded into fb_base_pc/fb_targ_addr, fb_valid <= 1, head advances. No pop leaves fb_valid <= 0; address outputs hold their last value.
- fb_valid is a one-cycle pulse per record; there is no backpressure from the consumer.
- Latency: resolution presented in cycle N (FIFO empty, en=1) is written at the end of N, popped at the end of N+1, and fb_valid is high in cycle N+2. No enqueue-to-output bypass.
- Back-to-back: a non-empty FIFO with en=1 emits one record every cycle.
- Simultaneous pop and enqueue in the same cycle is legal; fifo_cnt changes by (enqueued - popped).
- Pointers wrap modulo fifo_depth. fifo_cnt ranges 0..fifo_depth inclusive.
- en=0: no pop, and fb_valid <= 0 at the next edge. Enqueue and drop accounting continue.
- flush=1: at the next edge, FIFO emptied, fifo_cnt = 0, fb_valid <= 0. All same-cycle resolutions are discarded and are not counted in drop_cnt. drop_cnt is retained.
- Reset mid-operation: all buffered entries are lost, with no partial emission.

Test Plan:
- Single lane: cycle 0, lane0 valid, pc=0x100, targ=0x2000, en=1 -> fb_valid=1 only in cycle 2, fb_base_pc=0x100, fb_targ_addr=0x2000; fifo_cnt=1 in cycle 1, 0 in cycle 2.
- Coalescing: cycle 0, lanes 0..3 all valid, lanes 0 and 2 = (0x40, 0x800), lanes 1 and 3 = (0x44, 0x900) -> exactly two records, (0x40,0x800) in cycle 2 and (0x44,0x900) in cycle 3; drop_cnt=0.
- Overflow: en=0, three cycles of 4 distinct valid lanes (depth 8) -> fifo_cnt=8, drop_cnt=4. Raising en then yields the 8 records in lane/cycle order, one per cycle.
- Saturation: drop_cnt_width=4, sustained overflow of 20 drops -> drop_cnt holds 15.
- Flush: FIFO holding 5 entries, flush=1 for one cycle with 2 new valid lanes -> next cycle fifo_cnt=0, fb_valid=0, drop_cnt unchanged, no stale records afterward.
- Wrap/steady state: en=1, one new distinct lane every cycle for 20 cycles -> 20 records in order with fb_valid continuous from cycle 2 to cycle 21; head/tail wrap without loss.
